// File: rtl/udcount_seq.sv
// udcount_seq: command-driven sequencer that owns a WIDTH-bit up/down count.
// A requester hands over UP/DOWN/LOAD/CLEAR commands on a valid/ready
// handshake; UP/DOWN then step the count once per un-held cycle, and the block
// reports busy, a one-cycle done pulse and a one-cycle wrap pulse.
module udcount_seq #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         cmd_valid,
  output logic                                         cmd_ready,
  input  logic [1:0]                                   cmd_op,
  input  logic [((WIDTH > STEP_W) ? WIDTH : STEP_W)-1:0] cmd_arg,
  input  logic                                         hold,
  output logic [WIDTH-1:0]                             q,
  output logic                                         u_d,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_UP    = 2'b00;
  localparam logic [1:0] OP_DOWN  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                ud_q, ud_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic                wrap_q, wrap_d;
  logic [STEP_W-1:0]   stepArg;

  assign stepArg = cmd_arg[STEP_W-1:0];

  // State, count, direction, step budget and wrap flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      ud_q    <= 1'b1;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ud_q    <= ud_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state logic: accept commands in IDLE, step in RUN, retire via DONE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ud_d    = ud_q;
    rem_d   = rem_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_UP, OP_DOWN: begin
              ud_d = (cmd_op == OP_UP);
              if (stepArg != '0) begin
                rem_d   = stepArg;
                state_d = RUN;
              end else begin
                state_d = DONE;
              end
            end
            OP_LOAD: begin
              count_d = cmd_arg[WIDTH-1:0];
              state_d = DONE;
            end
            OP_CLEAR: begin
              count_d = '0;
              state_d = DONE;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      RUN: begin
        if (!hold) begin
          if (ud_q) begin
            count_d = count_q + WIDTH'(1);
            wrap_d  = (count_q == {WIDTH{1'b1}});
          end else begin
            count_d = count_q - WIDTH'(1);
            wrap_d  = (count_q == '0);
          end
          rem_d = rem_q - STEP_W'(1);
          if (rem_q == STEP_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign q         = count_q;
  assign u_d       = ud_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_udcount_seq.sv
// Self-checking bench for udcount_seq: per-cycle expectations are built from
// the command, the hold schedule and the current count, queued when the
// command is driven, and popped and compared at each falling edge.
module tb_udcount_seq;

  localparam logic [1:0] OP_UP    = 2'b00;
  localparam logic [1:0] OP_DOWN  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic       hold;
  logic [3:0] q;
  logic       u_d;
  logic       busy;
  logic       done;
  logic       wrap;

  // flags = {cmd_ready, busy, done, wrap, u_d}
  typedef struct {
    logic [3:0] q;
    logic [4:0] flags;
  } exp_t;

  exp_t sbQ[$];

  int checks   = 0;
  int failures = 0;

  logic [3:0] mQ;
  logic       mUd;

  udcount_seq #(.WIDTH(4), .STEP_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .hold      (hold),
    .q         (q),
    .u_d       (u_d),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
    end
  endtask

  function automatic exp_t mkExp(logic [3:0] eq, logic rdy, logic bsy, logic dn, logic wr, logic ud);
    exp_t e;
    e.q     = eq;
    e.flags = {rdy, bsy, dn, wr, ud};
    return e;
  endfunction

  // Drive one command at the current falling edge and check every cycle
  // until the block is back in IDLE. holdMask[j]/validMask[j] give the hold
  // and stray cmd_valid levels seen by the j-th rising edge after the accept
  // edge (j=0 is the accept edge itself).
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [3:0] arg,
                               input logic [15:0] holdMask, input logic [15:0] validMask);
    logic [3:0] curQ;
    logic       curUd;
    int         stepsDone;
    int         j;
    int         idx;
    exp_t       e;
    logic       wr;

    curQ  = mQ;
    curUd = mUd;
    if (op == OP_UP || op == OP_DOWN) curUd = (op == OP_UP);
    if (op == OP_LOAD)  curQ = arg;
    if (op == OP_CLEAR) curQ = 4'd0;

    if ((op == OP_UP || op == OP_DOWN) && arg != 4'd0) begin
      sbQ.push_back(mkExp(curQ, 1'b0, 1'b1, 1'b0, 1'b0, curUd));
      stepsDone = 0;
      j = 1;
      while (stepsDone < int'(arg)) begin
        if (holdMask[j]) begin
          sbQ.push_back(mkExp(curQ, 1'b0, 1'b1, 1'b0, 1'b0, curUd));
        end else begin
          wr = curUd ? (curQ == 4'd15) : (curQ == 4'd0);
          curQ = curUd ? curQ + 4'd1 : curQ - 4'd1;
          stepsDone++;
          sbQ.push_back(mkExp(curQ, 1'b0, 1'b1, (stepsDone == int'(arg)), wr, curUd));
        end
        j++;
      end
    end else begin
      sbQ.push_back(mkExp(curQ, 1'b0, 1'b1, 1'b1, 1'b0, curUd));
    end
    sbQ.push_back(mkExp(curQ, 1'b1, 1'b0, 1'b0, 1'b0, curUd));
    mQ  = curQ;
    mUd = curUd;

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    hold      = holdMask[0];
    idx = 0;
    while (sbQ.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      e = sbQ.pop_front();
      checkOutput($sformatf("%s q c%0d", tag, idx), {28'd0, q}, {28'd0, e.q});
      checkOutput($sformatf("%s flags c%0d", tag, idx),
                  {27'd0, cmd_ready, busy, done, wrap, u_d}, {27'd0, e.flags});
      idx++;
      // Stray commands during RUN use LOAD 9 so any acceptance shows on q.
      cmd_valid = (idx < 16) ? validMask[idx] : 1'b0;
      cmd_op    = OP_LOAD;
      cmd_arg   = 4'd9;
      hold      = (idx < 16) ? holdMask[idx] : 1'b0;
    end
    cmd_valid = 1'b0;
    hold      = 1'b0;
  endtask

  // Reset asserted between edges in the middle of an UP 10 run.
  task automatic checkMidRunReset();
    applyStimulus("clr0", OP_CLEAR, 4'd0, 16'h0, 16'h0);
    cmd_valid = 1'b1;
    cmd_op    = OP_UP;
    cmd_arg   = 4'd10;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("rst run start", {27'd0, cmd_ready, busy, done, wrap, u_d}, 32'b01001);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("rst step%0d q", i), {28'd0, q}, i);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst async q", {28'd0, q}, 32'd0);
    checkOutput("rst async flags", {27'd0, cmd_ready, busy, done, wrap, u_d}, 32'b10001);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("post rst q c%0d", i), {28'd0, q}, 32'd0);
      checkOutput($sformatf("post rst flags c%0d", i),
                  {27'd0, cmd_ready, busy, done, wrap, u_d}, 32'b10001);
    end
    mQ  = 4'd0;
    mUd = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = 4'd0;
    hold      = 1'b0;
    mQ        = 4'd0;
    mUd       = 1'b1;
    #12;
    checkOutput("reset q", {28'd0, q}, 32'd0);
    checkOutput("reset flags", {27'd0, cmd_ready, busy, done, wrap, u_d}, 32'b10001);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("up5",    OP_UP,    4'd5,  16'h0,      16'h0);
    applyStimulus("load14", OP_LOAD,  4'd14, 16'h0,      16'h0);
    applyStimulus("up3",    OP_UP,    4'd3,  16'h0,      16'h0);
    applyStimulus("clear",  OP_CLEAR, 4'd5,  16'h0,      16'h0);
    applyStimulus("down2",  OP_DOWN,  4'd2,  16'h0,      16'h0);
    applyStimulus("clear2", OP_CLEAR, 4'd0,  16'h0,      16'h0);
    applyStimulus("up4h",   OP_UP,    4'd4,  16'b11001,  16'b01100);
    applyStimulus("down0",  OP_DOWN,  4'd0,  16'h1,      16'h0);
    applyStimulus("load7",  OP_LOAD,  4'd7,  16'h0,      16'h0);
    applyStimulus("down3",  OP_DOWN,  4'd3,  16'h1,      16'b0010);
    checkMidRunReset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
